// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant, encoded id and
// a per-grant hold timeout that masks the offender until it drops its request.
module rr_arbiter4 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] arb_req,
   output logic [3:0] arb_grant,
   output logic [1:0] arb_grant_id,
   output logic       arb_busy,
   output logic       arb_timeout
);

   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_GRANT = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

   logic [0:0]       state_q, state_d;
   logic [3:0]       grant_q, grant_d;
   logic [1:0]       id_q, id_d;
   logic [1:0]       last_q, last_d;
   logic [3:0]       mask_q, mask_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;
   logic [3:0]       eff_s;
   logic [3:0]       mask_set_s;
   logic [2:0]       pick_s;

   // Returns {valid, id}: first set bit of eff searching upward from last+1.
   function automatic logic [2:0] pick_next(input logic [3:0] eff, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         idx = last + 2'(i);
         if (eff[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Next-state logic for the grant FSM, hold counter and timeout mask.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      id_d       = id_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
      mask_set_s = 4'b0000;
      eff_s      = arb_req & ~mask_q;
      pick_s     = pick_next(eff_s, last_q);

      case (state_q)
         ST_IDLE: begin
            if (pick_s[2]) begin
               grant_d = 4'b0001 << pick_s[1:0];
               id_d    = pick_s[1:0];
               last_d  = pick_s[1:0];
               cnt_d   = CNT_ONE;
               state_d = ST_GRANT;
            end else begin
               grant_d = 4'b0000;
               id_d    = 2'd0;
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            // Release wins over a coincident timeout.
            if (!arb_req[id_q]) begin
               grant_d = 4'b0000;
               id_d    = 2'd0;
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_IDLE;
            end else if ((MAX_HOLD != 32'd0) && (cnt_q == HOLD_LIM)) begin
               grant_d    = 4'b0000;
               id_d       = 2'd0;
               cnt_d      = {CNT_W{1'b0}};
               timeout_d  = 1'b1;
               mask_set_s = grant_q;
               state_d    = ST_IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            grant_d = 4'b0000;
            id_d    = 2'd0;
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_IDLE;
         end
      endcase

      mask_d = (mask_q | mask_set_s) & arb_req;
      busy_d = |grant_d;
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= 4'b0000;
         id_q      <= 2'd0;
         last_q    <= 2'd3;
         mask_q    <= 4'b0000;
         cnt_q     <= {CNT_W{1'b0}};
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         id_q      <= id_d;
         last_q    <= last_d;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign arb_grant    = grant_q;
   assign arb_grant_id = id_q;
   assign arb_busy     = busy_q;
   assign arb_timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4 with MAX_HOLD = 4.
module tb_rr_arbiter4;

   logic       clk;
   logic       rst;
   logic [3:0] arb_req;
   logic [3:0] arb_grant;
   logic [1:0] arb_grant_id;
   logic       arb_busy;
   logic       arb_timeout;

   int n_checks;
   int n_fails;

   rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .arb_req      (arb_req),
      .arb_grant    (arb_grant),
      .arb_grant_id (arb_grant_id),
      .arb_busy     (arb_busy),
      .arb_timeout  (arb_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Packs {grant, id, busy, timeout}; busy is expected to mirror the grant.
   task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic to);
      check(tag, {24'd0, arb_grant, arb_grant_id, arb_busy, arb_timeout},
            {24'd0, g, id, |g, to});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] req);
      rst     = 1'b1;
      arb_req = req;
      tick();
      expect_out("reset_c1", 4'b0000, 2'd0, 1'b0);
      tick();
      expect_out("reset_c2", 4'b0000, 2'd0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst      = 1'b1;
      arb_req  = 4'b0000;
      #2;

      // Reset with all requesters active, then round-robin rotation.
      do_reset(4'b1111);
      tick();
      for (int n = 0; n < 5; n++) begin
         logic [1:0] eid;
         eid = 2'(n % 4);
         expect_out($sformatf("rr_grant%0d_a", n), 4'b0001 << eid, eid, 1'b0);
         tick();
         expect_out($sformatf("rr_grant%0d_b", n), 4'b0001 << eid, eid, 1'b0);
         tick();
         expect_out($sformatf("rr_grant%0d_c", n), 4'b0001 << eid, eid, 1'b0);
         arb_req[eid] = 1'b0;
         tick();
         expect_out($sformatf("rr_gap%0d", n), 4'b0000, 2'd0, 1'b0);
         arb_req = 4'b1111;
         tick();
      end

      // Sparse requests 1 and 3.
      do_reset(4'b1010);
      tick();
      expect_out("sparse_g1", 4'b0010, 2'd1, 1'b0);
      arb_req = 4'b1000;
      tick();
      expect_out("sparse_rel1", 4'b0000, 2'd0, 1'b0);
      arb_req = 4'b1010;
      tick();
      expect_out("sparse_g3", 4'b1000, 2'd3, 1'b0);
      arb_req = 4'b0010;
      tick();
      expect_out("sparse_rel3", 4'b0000, 2'd0, 1'b0);
      arb_req = 4'b1010;
      tick();
      expect_out("sparse_g1_again", 4'b0010, 2'd1, 1'b0);

      // Timeout after exactly four grant cycles.
      do_reset(4'b0001);
      for (int c = 1; c <= 4; c++) begin
         tick();
         expect_out($sformatf("hold_c%0d", c), 4'b0001, 2'd0, 1'b0);
      end
      tick();
      expect_out("timeout_pulse", 4'b0000, 2'd0, 1'b1);
      tick();
      expect_out("masked_1", 4'b0000, 2'd0, 1'b0);
      tick();
      expect_out("masked_2", 4'b0000, 2'd0, 1'b0);
      arb_req = 4'b0000;
      tick();
      expect_out("mask_clear", 4'b0000, 2'd0, 1'b0);
      arb_req = 4'b0001;
      tick();
      expect_out("regrant_c1", 4'b0001, 2'd0, 1'b0);

      // Release on the same edge the counter hits the limit.
      tick();
      tick();
      tick();
      expect_out("regrant_c4", 4'b0001, 2'd0, 1'b0);
      arb_req = 4'b0000;
      tick();
      expect_out("rel_at_limit", 4'b0000, 2'd0, 1'b0);
      arb_req = 4'b0001;
      tick();
      expect_out("no_mask_after_rel", 4'b0001, 2'd0, 1'b0);

      // Requester 1 granted, others must not preempt; next grant goes to 2.
      arb_req = 4'b0000;
      tick();
      expect_out("idle_before_r1", 4'b0000, 2'd0, 1'b0);
      arb_req = 4'b0010;
      tick();
      expect_out("grant_r1", 4'b0010, 2'd1, 1'b0);
      arb_req = 4'b0111;
      tick();
      expect_out("no_preempt", 4'b0010, 2'd1, 1'b0);
      arb_req = 4'b0110;
      tick();
      expect_out("hold_r1", 4'b0010, 2'd1, 1'b0);
      arb_req = 4'b0100;
      tick();
      expect_out("rel_r1", 4'b0000, 2'd0, 1'b0);
      tick();
      expect_out("grant_r2", 4'b0100, 2'd2, 1'b0);

      // Asynchronous reset between edges while requester 2 holds the grant.
      #2;
      rst = 1'b1;
      #1;
      expect_out("async_reset", 4'b0000, 2'd0, 1'b0);
      arb_req = 4'b1111;
      tick();
      expect_out("reset_held", 4'b0000, 2'd0, 1'b0);
      rst = 1'b0;
      tick();
      expect_out("post_reset_g0", 4'b0001, 2'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
